// File: rtl/pipelined_adder.sv
// Segmented ripple adder, one SEG-bit slice per stage, with a global valid/ready stall.
// Define PIPELINED_ADDER_SUB_EN to add the sub input (x + ~y + 1).
module pipelined_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_in,
`ifdef PIPELINED_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int NSEG = WIDTH / SEG;

    logic             advance;
    logic [WIDTH-1:0] y_eff;
    logic             c_eff;

`ifdef PIPELINED_ADDER_SUB_EN
    assign y_eff = sub ? ~y : y;
    assign c_eff = sub | c_in;
`else
    assign y_eff = y;
    assign c_eff = c_in;
`endif

    logic [WIDTH-1:0] a_q [NSEG];
    logic [WIDTH-1:0] a_d [NSEG];
    logic [WIDTH-1:0] b_q [NSEG];
    logic [WIDTH-1:0] b_d [NSEG];
    logic [WIDTH-1:0] s_q [NSEG];
    logic [WIDTH-1:0] s_d [NSEG];
    logic [NSEG-1:0]  c_q;
    logic [NSEG-1:0]  c_d;
    logic [NSEG-1:0]  v_q;
    logic [NSEG-1:0]  v_d;

    assign advance   = !v_q[NSEG-1] || out_ready;
    assign in_ready  = advance;

    genvar k;
    for (k = 0; k < NSEG; k++) begin : g_stage
        logic [WIDTH-1:0] ai;
        logic [WIDTH-1:0] bi;
        logic [WIDTH-1:0] si;
        logic             ci;
        logic             vi;
        logic [SEG:0]     seg;

        if (k == 0) begin : g_first
            // Operands are zeroed for bubbles so idle inputs never reach the datapath.
            assign ai = in_valid ? x : '0;
            assign bi = in_valid ? y_eff : '0;
            assign si = '0;
            assign ci = in_valid & c_eff;
            assign vi = in_valid;
        end else begin : g_next
            assign ai = a_q[k-1];
            assign bi = b_q[k-1];
            assign si = s_q[k-1];
            assign ci = c_q[k-1];
            assign vi = v_q[k-1];
        end

        assign seg    = {1'b0, ai[k*SEG +: SEG]}
                      + {1'b0, bi[k*SEG +: SEG]}
                      + {{SEG{1'b0}}, ci};
        assign a_d[k] = ai;
        assign b_d[k] = bi;
        assign s_d[k] = si | (WIDTH'(seg[SEG-1:0]) << (k * SEG));
        assign c_d[k] = seg[SEG];
        assign v_d[k] = vi;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            c_q <= '0;
            for (int i = 0; i < NSEG; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                s_q[i] <= '0;
            end
        end else if (advance) begin
            v_q <= v_d;
            c_q <= c_d;
            for (int i = 0; i < NSEG; i++) begin
                a_q[i] <= a_d[i];
                b_q[i] <= b_d[i];
                s_q[i] <= s_d[i];
            end
        end
    end

    assign out_valid = v_q[NSEG-1];
    assign sum       = s_q[NSEG-1];
    assign c_out     = c_q[NSEG-1];
    // Carry into the MSB is recovered from the MSB operand and result bits.
    assign ovf       = a_q[NSEG-1][WIDTH-1] ^ b_q[NSEG-1][WIDTH-1]
                     ^ s_q[NSEG-1][WIDTH-1] ^ c_q[NSEG-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, SEG=4): directed table,
// stall, reset and randomized traffic against an arithmetic scoreboard.
module tb_pipelined_adder;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] x = '0;
    logic [W-1:0] y = '0;
    logic         c_in = 1'b0;
    logic         sub_r = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;

    int errors = 0;
    int checks = 0;
    int ndeliv = 0;

    logic [17:0] expq[$];
    logic        stall_prev = 1'b0;
    logic [17:0] prev_out = '0;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic        ci;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(16), .SEG(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .c_in      (c_in),
`ifdef PIPELINED_ADDER_SUB_EN
        .sub       (sub_r),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    // Reference: plain integer addition, overflow from the sign rule.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci, input logic sb);
        logic [16:0] t;
        logic [15:0] bb;
        logic        cc;
        logic        ov;
        bb = sb ? ~b : b;
        cc = sb ? 1'b1 : ci;
        t  = {1'b0, a} + {1'b0, bb} + {16'b0, cc};
        ov = (a[15] == bb[15]) && (t[15] != a[15]);
        return {t[16], ov, t[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready_rule", {31'b0, in_ready}, {31'b0, !out_valid || out_ready});
            if (stall_prev && out_valid)
                chk("stall_stable", {14'b0, c_out, ovf, sum}, {14'b0, prev_out});
            stall_prev = out_valid && !out_ready;
            prev_out   = {c_out, ovf, sum};
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("spurious_out", 32'd1, 32'd0);
                end else begin
                    chk("sb_result", {14'b0, c_out, ovf, sum}, {14'b0, expq.pop_front()});
                    ndeliv++;
                end
            end
            if (in_valid && in_ready)
                expq.push_back(model(x, y, c_in, sub_r));
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int lat;
        bit got;
        x = v.x;
        y = v.y;
        c_in = v.ci;
        in_valid = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            in_valid = 1'b0;
            x = 16'($urandom);
            y = 16'($urandom);
            c_in = 1'($urandom);
            @(negedge clk);
            if (out_valid) got = 1'b1;
        end
        chk({nm, "_lat"}, lat, 32'd4);
        chk({nm, "_res"}, {14'b0, c_out, ovf, sum}, {14'b0, v.co, v.ov, v.s});
        tick();
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (expq.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk(nm, expq.size(), 32'd0);
    endtask

    initial begin
        int acc;
        int d0;
        int sent;
        int lo;
        int cyc;
        int seen;
        bit need_new;

        tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[4] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
        tbl[7] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

        #2;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_sum", {16'b0, sum}, 32'd0);
        chk("rst_c_out", {31'b0, c_out}, 32'd0);
        chk("rst_ovf", {31'b0, ovf}, 32'd0);
        @(posedge clk);
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_vec(tbl[i], $sformatf("vec%0d", i));

        // Full-rate streaming
        d0 = ndeliv;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            c_in = 1'($urandom);
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        chk("throughput_acc", acc, 32'd10);
        drain("throughput_drain");
        chk("throughput_deliv", ndeliv - d0, 32'd10);

        // Eight beats with out_ready low in cycles 3-6
        d0 = ndeliv;
        sent = 0;
        lo = 0;
        cyc = 0;
        need_new = 1'b1;
        while ((sent < 8 || expq.size() != 0) && cyc < 60) begin
            cyc++;
            out_ready = !(cyc >= 3 && cyc <= 6);
            if (sent < 8) begin
                if (need_new) begin
                    x = 16'($urandom);
                    y = 16'($urandom);
                    c_in = 1'($urandom);
                    need_new = 1'b0;
                end
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (!in_ready) lo++;
            if (in_valid && in_ready) begin
                sent++;
                need_new = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stall_inready_low", lo, 32'd2);
        chk("stall_deliv", ndeliv - d0, 32'd8);

        // Randomized traffic and backpressure
        for (int i = 0; i < 300; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            x = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            y = 16'($urandom);
            c_in = 1'($urandom);
`ifdef PIPELINED_ADDER_SUB_EN
            sub_r = 1'($urandom);
`endif
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        sub_r = 1'b0;
        drain("random_drain");

        // Reset with three beats in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            c_in = 1'($urandom);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("pre_reset_valid", {31'b0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_async_sum", {16'b0, sum}, 32'd0);
        chk("rst_async_ready", {31'b0, in_ready}, 32'd1);
        expq.delete();
        @(posedge clk);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("rst_no_ghost", seen, 32'd0);
        tick();
        run_vec(tbl[4], "post_reset");

`ifdef PIPELINED_ADDER_SUB_EN
        sub_r = 1'b1;
        run_vec('{16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0}, "sub");
        sub_r = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
